// File: rtl/pixel_frame_controller.sv
// Global-shutter frame sequencer: erase, expose, ramp-ADC conversion, bus
// turnaround, then two-cycle-per-row readout. Every output is a flop.
module pixel_frame_controller #(
    parameter int ERASE_CYCLES = 5,
    parameter int COUNTER_BITS = 8,
    parameter int NUM_ROWS     = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [7:0]              expose_time,
    output logic                    erase,
    output logic                    expose,
    output logic                    ramp_en,
    output logic [COUNTER_BITS-1:0] adc_count,
    output logic                    adc_drive,
    output logic [NUM_ROWS-1:0]     read_row,
    output logic                    rd_valid,
    output logic [3:0]              rd_row_idx,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_TURN    = 3'd4;
    localparam logic [2:0] S_READ    = 3'd5;

    localparam logic [7:0]              ERASE_LAST = 8'(ERASE_CYCLES - 1);
    localparam logic [3:0]              LAST_ROW   = 4'(NUM_ROWS - 1);
    localparam logic [NUM_ROWS-1:0]     ROW0       = NUM_ROWS'(1);
    localparam logic [COUNTER_BITS-1:0] ADC_MAX    = {COUNTER_BITS{1'b1}};

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] t_len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            t_len      <= 8'd0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            ramp_en    <= 1'b0;
            adc_count  <= '0;
            adc_drive  <= 1'b0;
            read_row   <= '0;
            rd_valid   <= 1'b0;
            rd_row_idx <= 4'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Abort beats every transition and suppresses the done pulse.
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                cnt        <= 8'd0;
                erase      <= 1'b0;
                expose     <= 1'b0;
                ramp_en    <= 1'b0;
                adc_count  <= '0;
                adc_drive  <= 1'b0;
                read_row   <= '0;
                rd_valid   <= 1'b0;
                rd_row_idx <= 4'd0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state <= S_ERASE;
                            erase <= 1'b1;
                            busy  <= 1'b1;
                            cnt   <= 8'd0;
                            t_len <= (expose_time == 8'd0) ? 8'd1 : expose_time;
                        end
                    end
                    S_ERASE: begin
                        if (cnt == ERASE_LAST) begin
                            state  <= S_EXPOSE;
                            erase  <= 1'b0;
                            expose <= 1'b1;
                            cnt    <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_EXPOSE: begin
                        if (cnt == t_len - 8'd1) begin
                            state     <= S_CONVERT;
                            expose    <= 1'b0;
                            ramp_en   <= 1'b1;
                            adc_drive <= 1'b1;
                            adc_count <= '0;
                            cnt       <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    S_CONVERT: begin
                        if (adc_count == ADC_MAX) begin
                            state     <= S_TURN;
                            ramp_en   <= 1'b0;
                            adc_drive <= 1'b0;
                            adc_count <= '0;
                        end else begin
                            adc_count <= adc_count + COUNTER_BITS'(1);
                        end
                    end
                    S_TURN: begin
                        state      <= S_READ;
                        read_row   <= ROW0;
                        rd_row_idx <= 4'd0;
                        rd_valid   <= 1'b0;
                    end
                    S_READ: begin
                        // rd_valid doubles as the settle/valid phase bit.
                        if (!rd_valid) begin
                            rd_valid <= 1'b1;
                        end else if (rd_row_idx == LAST_ROW) begin
                            state      <= S_IDLE;
                            read_row   <= '0;
                            rd_valid   <= 1'b0;
                            rd_row_idx <= 4'd0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            read_row   <= read_row << 1;
                            rd_row_idx <= rd_row_idx + 4'd1;
                            rd_valid   <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_controller.sv
// Directed bench for pixel_frame_controller: walks whole frames edge by edge
// against a hand-derived timeline, plus abort, back-to-back and async reset.
module tb_pixel_frame_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] expose_time = 8'd0;
    logic       erase, expose, ramp_en, adc_drive, rd_valid, busy, frame_done;
    logic [7:0] adc_count;
    logic [1:0] read_row;
    logic [3:0] rd_row_idx;
    logic [20:0] obs;
    logic        fd_q = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pixel_frame_controller #(.ERASE_CYCLES(5), .COUNTER_BITS(8), .NUM_ROWS(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .expose_time(expose_time), .erase(erase), .expose(expose),
        .ramp_en(ramp_en), .adc_count(adc_count), .adc_drive(adc_drive),
        .read_row(read_row), .rd_valid(rd_valid), .rd_row_idx(rd_row_idx),
        .busy(busy), .frame_done(frame_done)
    );

    assign obs = {erase, expose, ramp_en, adc_drive, adc_count, read_row,
                  rd_valid, rd_row_idx, busy, frame_done};

    // Expected outputs seen at spec edge n, where start was sampled at edge 0.
    function automatic logic [20:0] exp_vec(input int n, input int tt);
        int t  = (tt == 0) ? 1 : tt;
        int a  = 5;
        int b  = 5 + t;
        int c  = b + 256;
        int tu = c + 1;
        int k;
        logic e = 0, x = 0, r = 0, d = 0, v = 0, bz = 0, fd = 0;
        logic [7:0] cn = 0;
        logic [1:0] rr = 0;
        logic [3:0] idx = 0;
        if (n >= 1 && n <= a) begin e = 1; bz = 1; end
        else if (n > a && n <= b) begin x = 1; bz = 1; end
        else if (n > b && n <= c) begin r = 1; d = 1; cn = 8'(n - b - 1); bz = 1; end
        else if (n == tu) bz = 1;
        else if (n > tu && n <= tu + 4) begin
            k = n - tu - 1;
            rr = 2'(1 << (k / 2));
            v = (k % 2) == 1;
            idx = 4'(k / 2);
            bz = 1;
        end
        else if (n == tu + 5) fd = 1;
        return {e, x, r, d, cn, rr, v, idx, bz, fd};
    endfunction

    task automatic chk(input string tag, input int n, input logic [20:0] o, input logic [20:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s n=%0d: observed %h expected %h", tag, n, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks edges n0..n1; ends at the sample point of n1 without advancing.
    task automatic walk(input string tag, input int tt, input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            chk(tag, n, obs, exp_vec(n, tt));
            if (n < n1) tick();
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            tests++;
            assert (!(erase && expose) && !(adc_drive && |read_row) &&
                    $onehot0(read_row) && !(frame_done && fd_q)) else begin
                fails++;
                $error("FAIL invariant: observed e=%b x=%b drv=%b row=%b fd=%b/%b expected exclusive",
                       erase, expose, adc_drive, read_row, frame_done, fd_q);
            end
            fd_q = frame_done;
        end else begin
            fd_q = 1'b0;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, obs, 21'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_after_reset", 0, obs, 21'h0);

        // Nominal frame; busy-time start pulse and expose_time change ignored.
        expose_time = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        walk("frame_t10", 10, 1, 100);
        start = 1'b1;
        expose_time = 8'd50;
        tick();
        start = 1'b0;
        walk("frame_t10", 10, 101, 280);

        // Zero exposure behaves as one cycle.
        expose_time = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        walk("frame_t0", 0, 1, 270);

        // start held: second frame starts on the edge after frame_done.
        expose_time = 8'd10;
        start = 1'b1;
        tick();
        walk("held_first", 10, 1, 277);
        tick();
        walk("held_second", 10, 1, 116);

        // Abort mid-conversion at adc_count=100.
        start = 1'b0;
        abort = 1'b1;
        tick();
        chk("abort_clear", 0, obs, 21'h0);
        abort = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("abort_no_done", i, obs, 21'h0);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_start_idle", 0, obs, 21'h0);
        abort = 1'b0;
        start = 1'b0;
        tick();
        chk("abort_start_idle2", 0, obs, 21'h0);

        start = 1'b1;
        tick();
        start = 1'b0;
        walk("after_abort", 10, 1, 275);

        // Async reset mid-READ with read_row=10, no clock edge needed.
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_async", 0, obs, 21'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_after_reset2", 0, obs, 21'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        walk("after_reset", 10, 1, 278);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pixel_frame_controller.md
Name: pixel_frame_controller

Overview:
- Sequences one global-shutter frame of the pixel-sensor array: erase, expose, ramp-ADC conversion, then row-by-row readout.
- Drives the array control lines and, during conversion, the shared 8-bit DATA bus with the ramp code that the in-pixel latches capture.
- Sits between the top-level frame trigger and the pixel-array/readout blocks.
- Single clock domain.

Parameters:
- ERASE_CYCLES, 5, clock cycles erase is held high (1..255).
- COUNTER_BITS, 8, ADC code width; conversion lasts 2^COUNTER_BITS cycles.
- NUM_ROWS, 2, number of pixel rows read out sequentially (1..16).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  frame request, sampled in IDLE only.
- abort  input  1  synchronous frame abort.
- expose_time  input  8  exposure length in cycles, latched when start is accepted.
- erase  output  1  pixel erase.
- expose  output  1  pixel expose enable.
- ramp_en  output  1  ramp generator enable, one ramp step per cycle.
- adc_count  output  COUNTER_BITS  ramp code driven onto DATA.
- adc_drive  output  1  tristate enable for adc_count onto DATA.
- read_row  output  NUM_ROWS  one-hot row read select.
- rd_valid  output  1  DATA holds a valid pixel row this cycle.
- rd_row_idx  output  4  index of the row being read.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse on frame completion.

Behaviour:
- All outputs are registered.
- Reset (reset_n low, asynchronous, any time including mid-frame):
  - State goes to IDLE.
  - All outputs and all counters clear to 0.
  - adc_drive and read_row are 0 immediately.
- States and transitions:
  - IDLE -> ERASE -> EXPOSE -> CONVERT -> TURN -> READ -> IDLE.
- IDLE:
  - All outputs 0 except frame_done, which may be in its pulse cycle.
  - start=1 sampled at edge k: latch T = expose_time, with 0 treated as 1.
  - erase=1 and busy=1 from edge k+1.
- ERASE:
  - erase=1 for exactly ERASE_CYCLES cycles.
  - Then expose=1 from the next edge.
- EXPOSE:
  - expose=1 for exactly T cycles.
  - erase and expose are never high in the same cycle.
- CONVERT:
  - ramp_en=1 and adc_drive=1 for 2^COUNTER_BITS cycles.
  - adc_count=0 in the first cycle and increments by 1 each cycle to 2^COUNTER_BITS-1.
  - No wrap: after the max value the FSM leaves CONVERT and adc_count returns to 0.
- TURN:
  - Exactly 1 cycle with adc_drive=0 and read_row=0 (bus turnaround).
  - adc_drive and any read_row bit are never high in the same cycle.
- READ:
  - Each row r (0..NUM_ROWS-1) takes 2 cycles, with read_row = 1<<r in both and rd_row_idx = r.
  - Cycle 1 is bus settle, rd_valid=0.
  - Cycle 2 has rd_valid=1.
  - Rows are read in ascending order with no gap.
- Completion:
  - After the last row's second cycle, the state returns to IDLE.
  - In that first IDLE cycle, frame_done=1 and busy=0.
- Frame length from the first erase cycle to the last read cycle is ERASE_CYCLES + T + 2^COUNTER_BITS + 1 + 2*NUM_ROWS cycles.
- Start handling:
  - start while busy is ignored (not queued).
  - start in the frame_done cycle is accepted, giving back-to-back frames.
- abort:
  - abort=1 in any non-IDLE state forces IDLE at the next edge with all outputs 0.
  - frame_done is not pulsed.
  - abort has priority over every state transition.
  - abort in IDLE has no effect, and when abort and start are both 1 in IDLE, start is not accepted.
- expose_time changes after acceptance have no effect on the current frame.

Test Plan:
- Defaults, expose_time=10, start pulse at edge 0:
  - erase high edges 1-5, expose high edges 6-15.
  - adc_count 0..255 with adc_drive=1 on edges 16-271; edge 272 all drives 0.
  - read_row=01 on edges 273-274 (rd_valid on 274), read_row=10 on edges 275-276 (rd_valid on 276).
  - frame_done=1 on edge 277.
- expose_time=0 -> expose high exactly 1 cycle; frame_done on edge 268.
- start held high continuously -> new erase begins on the edge after frame_done; start pulses during busy do not alter timing.
- abort asserted with adc_count=100 -> next edge: busy=0, adc_drive=0, adc_count=0, no frame_done; a later start gives a normal full frame.
- reset_n low mid-READ with read_row=10 -> read_row, rd_valid, busy drop to 0 without a clock edge; after release, IDLE and start behave normally.
- Assertions over all runs:
  - erase and expose never both high.
  - adc_drive and read_row never both nonzero.
  - read_row is always one-hot or zero.
  - frame_done is never high for 2 consecutive cycles.
